// File: rtl/lbm_dist_bank.sv
// Double-buffered lattice-Boltzmann distribution store: Q channels, two banks each, bulk init fill and bank swap.
// Optional channel-0 debug taps are enabled with `define LBM_DIST_BANK_DEBUG_EN.
module lbm_dist_bank #(
    parameter int Q          = 9,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int DEPTH      = 2500,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              init_start,
    input  logic [Q*DATA_WIDTH-1:0]           init_vals,
    input  logic                              rd_en,
    input  logic [Q*ADDR_WIDTH-1:0]           rd_addr,
    output logic [Q*DATA_WIDTH*LANES-1:0]     rd_data,
    output logic                              rd_valid,
    input  logic [Q-1:0]                      wr_en,
    input  logic [Q*ADDR_WIDTH-1:0]           wr_addr,
    input  logic [Q*DATA_WIDTH*LANES-1:0]     wr_data,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic                              bank_sel,
    output logic [31:0]                       step_count,
    output logic                              busy,
    output logic                              init_done,
    output logic                              addr_err
`ifdef LBM_DIST_BANK_DEBUG_EN
    ,
    output logic [DATA_WIDTH*LANES-1:0]       dbg_c0_wr_data,
    output logic [DATA_WIDTH*LANES-1:0]       dbg_c0_rd_data
`endif
);

    localparam int WORD_W = DATA_WIDTH * LANES;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     fill_q, fill_d;
    logic [Q*DATA_WIDTH-1:0]   init_vals_q, init_vals_d;
    logic                      bank_sel_q, bank_sel_d;
    logic [31:0]               step_count_q, step_count_d;
    logic                      swap_ack_q, swap_ack_d;
    logic                      init_done_q, init_done_d;
    logic                      addr_err_q, addr_err_d;
    logic                      rd_s1_valid_q, rd_s1_valid_d;
    logic [Q-1:0]              rd_oor_q, rd_oor_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [Q*WORD_W-1:0]       rd_data_q, rd_data_d;

    logic                      in_init;
    logic                      rd_accept;
    logic [Q-1:0]              rd_in_range;
    logic [Q-1:0]              wr_in_range;
    logic [Q-1:0]              wr_ok;
    logic                      err_hit;
    logic [Q*WORD_W-1:0]       wr_mux_flat;
    logic [Q*WORD_W-1:0]       rd_raw_flat;

    assign in_init   = (state_q == ST_INIT);
    assign rd_accept = rd_en && !in_init;

    always_comb begin
        // NOTE: every variable written here gets a default first so no path leaves it unassigned, which would infer a latch.
        rd_in_range = '0;
        wr_in_range = '0;
        for (int q = 0; q < Q; q++) begin
            rd_in_range[q] = 32'(rd_addr[q*ADDR_WIDTH +: ADDR_WIDTH]) < 32'(DEPTH);
            wr_in_range[q] = 32'(wr_addr[q*ADDR_WIDTH +: ADDR_WIDTH]) < 32'(DEPTH);
        end
    end

    assign wr_ok   = wr_en & wr_in_range & {Q{!in_init}};
    assign err_hit = (rd_accept && |(~rd_in_range)) || |(wr_en & ~wr_in_range & {Q{!in_init}});

    // Next-state logic; init_start overrides everything, including a same-cycle swap.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        init_vals_d  = init_vals_q;
        bank_sel_d   = bank_sel_q;
        step_count_d = step_count_q;
        swap_ack_d   = 1'b0;
        init_done_d  = 1'b0;
        addr_err_d   = addr_err_q | err_hit;

        case (state_q)
            ST_INIT: begin
                fill_d = fill_q + ADDR_WIDTH'(1);
                if (fill_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    fill_d      = '0;
                end
            end
            ST_RUN: begin
                if (swap_req) begin
                    bank_sel_d   = ~bank_sel_q;
                    swap_ack_d   = 1'b1;
                    step_count_d = step_count_q + 32'd1;
                end
            end
            default: ;
        endcase

        if (init_start) begin
            state_d      = ST_INIT;
            fill_d       = '0;
            init_vals_d  = init_vals;
            bank_sel_d   = 1'b0;
            step_count_d = '0;
            addr_err_d   = 1'b0;
            swap_ack_d   = 1'b0;
            init_done_d  = 1'b0;
        end
    end

    // Two-stage read: RAM word captured at the sampling edge, output register one edge later.
    always_comb begin
        rd_s1_valid_d = rd_accept && (state_d != ST_INIT);
        rd_oor_d      = rd_s1_valid_d ? ~rd_in_range : rd_oor_q;
        rd_valid_d    = rd_s1_valid_q && (state_d != ST_INIT);
        rd_data_d     = rd_data_q;
        if (rd_valid_d) begin
            for (int q = 0; q < Q; q++) begin
                rd_data_d[q*WORD_W +: WORD_W] = rd_oor_q[q] ? '0 : rd_raw_flat[q*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            fill_q        <= '0;
            init_vals_q   <= '0;
            bank_sel_q    <= 1'b0;
            step_count_q  <= '0;
            swap_ack_q    <= 1'b0;
            init_done_q   <= 1'b0;
            addr_err_q    <= 1'b0;
            rd_s1_valid_q <= 1'b0;
            rd_oor_q      <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            fill_q        <= fill_d;
            init_vals_q   <= init_vals_d;
            bank_sel_q    <= bank_sel_d;
            step_count_q  <= step_count_d;
            swap_ack_q    <= swap_ack_d;
            init_done_q   <= init_done_d;
            addr_err_q    <= addr_err_d;
            rd_s1_valid_q <= rd_s1_valid_d;
            rd_oor_q      <= rd_oor_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    for (genvar q = 0; q < Q; q++) begin : g_chan
        logic [WORD_W-1:0] mem_b0 [DEPTH];
        logic [WORD_W-1:0] mem_b1 [DEPTH];
        logic [WORD_W-1:0] wr_word;
        logic [WORD_W-1:0] rd_raw_q;
        logic [IDX_W-1:0]  w_idx;
        logic [IDX_W-1:0]  r_idx;
        logic              we_b0;
        logic              we_b1;

        assign wr_word = in_init ? {LANES{init_vals_q[q*DATA_WIDTH +: DATA_WIDTH]}}
                                 : wr_data[q*WORD_W +: WORD_W];
        assign w_idx   = in_init ? fill_q[IDX_W-1:0] : wr_addr[q*ADDR_WIDTH +: IDX_W];
        assign r_idx   = rd_addr[q*ADDR_WIDTH +: IDX_W];
        // Writes always target the bank that is not being read.
        assign we_b0   = in_init || (wr_ok[q] && bank_sel_q);
        assign we_b1   = in_init || (wr_ok[q] && !bank_sel_q);

        // NOTE: RAM arrays and their read register carry no reset so they map onto block RAM.
        always_ff @(posedge clk) begin
            if (we_b0) mem_b0[w_idx] <= wr_word;
            if (we_b1) mem_b1[w_idx] <= wr_word;
            if (rd_s1_valid_d) rd_raw_q <= bank_sel_q ? mem_b1[r_idx] : mem_b0[r_idx];
        end

        assign wr_mux_flat[q*WORD_W +: WORD_W] = wr_word;
        assign rd_raw_flat[q*WORD_W +: WORD_W] = rd_raw_q;
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign swap_ack   = swap_ack_q;
    assign bank_sel   = bank_sel_q;
    assign step_count = step_count_q;
    assign busy       = in_init;
    assign init_done  = init_done_q;
    assign addr_err   = addr_err_q;

`ifdef LBM_DIST_BANK_DEBUG_EN
    assign dbg_c0_wr_data = wr_mux_flat[WORD_W-1:0];
    assign dbg_c0_rd_data = rd_data_q[WORD_W-1:0];
`else
    // Debug taps absent; channel-0 write mux is consumed only by the RAMs.
`endif

endmodule

// File: tb/tb_lbm_dist_bank.sv
// Directed bench for lbm_dist_bank with Q=9, DEPTH=16: init fill, bank swap, write/read/swap overlap,
// range errors, reset during fill and step counter wrap.
module tb_lbm_dist_bank;

    localparam int Q     = 9;
    localparam int DW    = 16;
    localparam int LN    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 12;
    localparam int W     = DW * LN;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              init_start = 1'b0;
    logic [Q*DW-1:0]   init_vals = '0;
    logic              rd_en = 1'b0;
    logic [Q*AW-1:0]   rd_addr = '0;
    logic [Q*W-1:0]    rd_data;
    logic              rd_valid;
    logic [Q-1:0]      wr_en = '0;
    logic [Q*AW-1:0]   wr_addr = '0;
    logic [Q*W-1:0]    wr_data = '0;
    logic              swap_req = 1'b0;
    logic              swap_ack;
    logic              bank_sel;
    logic [31:0]       step_count;
    logic              busy;
    logic              init_done;
    logic              addr_err;

    int checks = 0;
    int errors = 0;

    lbm_dist_bank #(
        .Q(Q), .DATA_WIDTH(DW), .LANES(LN), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .init_start(init_start), .init_vals(init_vals),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .bank_sel(bank_sel),
        .step_count(step_count), .busy(busy), .init_done(init_done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [Q*W-1:0] fill_bus();
        logic [Q*W-1:0] b;
        for (int q = 0; q < Q; q++) b[q*W +: W] = {LN{16'(q + 1)}};
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd_addr_all(input int a);
        for (int q = 0; q < Q; q++) rd_addr[q*AW +: AW] = AW'(a);
    endtask

    task automatic start_init();
        init_start = 1'b1;
        for (int q = 0; q < Q; q++) init_vals[q*DW +: DW] = 16'(q + 1);
        tick();
        init_start = 1'b0;
    endtask

    task automatic wait_init(output int n, output bit done_seen);
        n = 0;
        done_seen = 1'b0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (init_done) done_seen = 1'b1;
        end
    endtask

    task automatic read_word(input int a, output logic [Q*W-1:0] data, output logic v1, output logic v2);
        rd_en = 1'b1;
        set_rd_addr_all(a);
        tick();
        rd_en = 1'b0;
        v1 = rd_valid;
        tick();
        v2 = rd_valid;
        data = rd_data;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if ({rd_valid, swap_ack, bank_sel, busy, init_done, addr_err} !== 6'b0) begin
            $display("FAIL reset_flags: got %b expected 000000", {rd_valid, swap_ack, bank_sel, busy, init_done, addr_err});
            errors++;
        end
        checks++;
        if (step_count !== 32'd0) begin
            $display("FAIL reset_step_count: got %h expected 0", step_count);
            errors++;
        end
        checks++;
        if (rd_data !== '0) begin
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
            errors++;
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_init_fill();
        int n;
        bit done_seen;
        logic [Q*W-1:0] d;
        logic v1, v2;
        start_init();
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL init_busy_rise: got %b expected 1", busy);
            errors++;
        end
        wait_init(n, done_seen);
        checks++;
        if (n !== 16 || done_seen !== 1'b1 || init_done !== 1'b1) begin
            $display("FAIL init_length: got cycles=%0d done_seen=%b init_done=%b expected cycles=16 done_seen=1 init_done=1", n, done_seen, init_done);
            errors++;
        end
        tick();
        checks++;
        if (init_done !== 1'b0 || busy !== 1'b0 || bank_sel !== 1'b0) begin
            $display("FAIL init_after: got init_done=%b busy=%b bank_sel=%b expected 0 0 0", init_done, busy, bank_sel);
            errors++;
        end
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                read_word(a, d, v1, v2);
                checks++;
                if (v1 !== 1'b0 || v2 !== 1'b1 || d !== fill_bus()) begin
                    $display("FAIL init_read bank%0d addr%0d: got v=%b%b data=%h expected v=01 data=%h", b, a, v1, v2, d, fill_bus());
                    errors++;
                end
            end
            do_swap();
            checks++;
            if (swap_ack !== 1'b1 || bank_sel !== (b == 0) || step_count !== 32'(b + 1)) begin
                $display("FAIL init_swap%0d: got ack=%b bank_sel=%b steps=%0d expected ack=1 bank_sel=%b steps=%0d", b, swap_ack, bank_sel, step_count, b == 0, b + 1);
                errors++;
            end
        end
        tick();
        checks++;
        if (swap_ack !== 1'b0) begin
            $display("FAIL swap_ack_pulse: got %b expected 0", swap_ack);
            errors++;
        end
    endtask

    task automatic test_write_then_swap();
        logic [Q*W-1:0] d, exp_d;
        logic v1, v2;
        wr_en = 9'b1 << 4;
        wr_addr[4*AW +: AW] = AW'(3);
        wr_data[4*W +: W] = 64'h00AA_00BB_00CC_00DD;
        tick();
        wr_en = '0;
        read_word(3, d, v1, v2);
        checks++;
        if (d !== fill_bus() || v2 !== 1'b1) begin
            $display("FAIL write_current_untouched: got %h expected %h", d, fill_bus());
            errors++;
        end
        do_swap();
        checks++;
        if (swap_ack !== 1'b1 || bank_sel !== 1'b1 || step_count !== 32'd3) begin
            $display("FAIL write_swap: got ack=%b bank_sel=%b steps=%0d expected 1 1 3", swap_ack, bank_sel, step_count);
            errors++;
        end
        read_word(3, d, v1, v2);
        exp_d = fill_bus();
        exp_d[4*W +: W] = 64'h00AA_00BB_00CC_00DD;
        checks++;
        if (v1 !== 1'b0 || v2 !== 1'b1 || d !== exp_d) begin
            $display("FAIL write_readback: got v=%b%b data=%h expected v=01 data=%h", v1, v2, d, exp_d);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [Q*W-1:0] exp_a, exp_b;
        exp_a = fill_bus();
        exp_a[4*W +: W] = 64'h00AA_00BB_00CC_00DD;
        exp_b = fill_bus();
        exp_b[2*W +: W] = 64'h1234_5678_9ABC_DEF0;
        wr_en = 9'b1 << 2;
        wr_addr[2*AW +: AW] = AW'(5);
        wr_data[2*W +: W] = 64'h1234_5678_9ABC_DEF0;
        swap_req = 1'b1;
        rd_en = 1'b1;
        set_rd_addr_all(3);
        tick();
        wr_en = '0;
        swap_req = 1'b0;
        set_rd_addr_all(5);
        checks++;
        if (swap_ack !== 1'b1 || bank_sel !== 1'b0 || step_count !== 32'd4) begin
            $display("FAIL b2b_swap: got ack=%b bank_sel=%b steps=%0d expected 1 0 4", swap_ack, bank_sel, step_count);
            errors++;
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_a) begin
            $display("FAIL b2b_read_preswap: got v=%b data=%h expected v=1 data=%h", rd_valid, rd_data, exp_a);
            errors++;
        end
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
            $display("FAIL b2b_read_postswap: got v=%b data=%h expected v=1 data=%h", rd_valid, rd_data, exp_b);
            errors++;
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || step_count !== 32'd4) begin
            $display("FAIL b2b_settle: got v=%b steps=%0d expected v=0 steps=4", rd_valid, step_count);
            errors++;
        end
    endtask

    task automatic test_addr_err();
        logic [Q*W-1:0] d, exp_d;
        logic v1, v2;
        int n;
        bit done_seen;
        rd_en = 1'b1;
        set_rd_addr_all(0);
        rd_addr[0 +: AW] = AW'(16);
        wr_en = 9'b1 << 1;
        wr_addr[1*AW +: AW] = AW'(16);
        wr_data[1*W +: W] = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        rd_en = 1'b0;
        wr_en = '0;
        checks++;
        if (addr_err !== 1'b1) begin
            $display("FAIL addr_err_set: got %b expected 1", addr_err);
            errors++;
        end
        tick();
        exp_d = fill_bus();
        exp_d[0 +: W] = '0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
            $display("FAIL oor_read_zero: got v=%b data=%h expected v=1 data=%h", rd_valid, rd_data, exp_d);
            errors++;
        end
        do_swap();
        read_word(0, d, v1, v2);
        checks++;
        if (d !== fill_bus() || bank_sel !== 1'b1) begin
            $display("FAIL oor_write_dropped: got bank_sel=%b data=%h expected bank_sel=1 data=%h", bank_sel, d, fill_bus());
            errors++;
        end
        repeat (3) tick();
        checks++;
        if (addr_err !== 1'b1) begin
            $display("FAIL addr_err_sticky: got %b expected 1", addr_err);
            errors++;
        end
        start_init();
        checks++;
        if (addr_err !== 1'b0 || bank_sel !== 1'b0 || step_count !== 32'd0 || busy !== 1'b1) begin
            $display("FAIL init_clears: got err=%b bank_sel=%b steps=%0d busy=%b expected 0 0 0 1", addr_err, bank_sel, step_count, busy);
            errors++;
        end
        wait_init(n, done_seen);
        checks++;
        if (n !== 16 || done_seen !== 1'b1) begin
            $display("FAIL reinit_length: got cycles=%0d done=%b expected 16 1", n, done_seen);
            errors++;
        end
    endtask

    task automatic test_reset_mid_init();
        start_init();
        repeat (7) tick();
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL mid_init_busy: got %b expected 1", busy);
            errors++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rd_valid, swap_ack, bank_sel, busy, init_done, addr_err} !== 6'b0 || step_count !== 32'd0 || rd_data !== '0) begin
            $display("FAIL async_reset: got flags=%b steps=%0d data=%h expected all zero", {rd_valid, swap_ack, bank_sel, busy, init_done, addr_err}, step_count, rd_data);
            errors++;
        end
        tick();
        rst = 1'b1;
        tick();
        do_swap();
        checks++;
        if (swap_ack !== 1'b0 || bank_sel !== 1'b0 || step_count !== 32'd0 || busy !== 1'b0) begin
            $display("FAIL idle_swap_ignored: got ack=%b bank_sel=%b steps=%0d busy=%b expected 0 0 0 0", swap_ack, bank_sel, step_count, busy);
            errors++;
        end
    endtask

    task automatic test_step_wrap();
        int n;
        bit done_seen;
        start_init();
        wait_init(n, done_seen);
        checks++;
        if (n !== 16 || done_seen !== 1'b1) begin
            $display("FAIL wrap_init: got cycles=%0d done=%b expected 16 1", n, done_seen);
            errors++;
        end
        force dut.step_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.step_count_q;
        checks++;
        if (step_count !== 32'hFFFF_FFFF) begin
            $display("FAIL wrap_preload: got %h expected ffffffff", step_count);
            errors++;
        end
        do_swap();
        checks++;
        if (step_count !== 32'd0 || bank_sel !== 1'b1 || swap_ack !== 1'b1) begin
            $display("FAIL wrap_to_zero: got steps=%h bank_sel=%b ack=%b expected 0 1 1", step_count, bank_sel, swap_ack);
            errors++;
        end
        do_swap();
        checks++;
        if (step_count !== 32'd1 || bank_sel !== 1'b0) begin
            $display("FAIL wrap_next: got steps=%h bank_sel=%b expected 1 0", step_count, bank_sel);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_init_fill();
        test_write_then_swap();
        test_back_to_back();
        test_addr_err();
        test_reset_mid_init();
        test_step_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbm_dist_bank.md
LBM_DIST_BANK -- requirements
Module: lbm_dist_bank

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- Q, 9, number of lattice directions (channels).
- DATA_WIDTH, 16, bits per lane sample, two's complement.
- LANES, 4, parallel lanes per RAM word.
- DEPTH, 2500, words per RAM.
- ADDR_WIDTH, 12, address bits; DEPTH <= 2^ADDR_WIDTH.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock.
- rst, in, 1, reset; asynchronous, active-low.
- init_start, in, 1, pulse; begins the fill of both banks.
- init_vals, in, Q*DATA_WIDTH, per-channel initial sample.
- rd_en, in, 1, read strobe for all channels.
- rd_addr, in, Q*ADDR_WIDTH, per-channel read address.
- rd_data, out, Q*DATA_WIDTH*LANES, per-channel read word.
- rd_valid, out, 1, rd_data valid.
- wr_en, in, Q, per-channel write strobe.
- wr_addr, in, Q*ADDR_WIDTH, per-channel write address.
- wr_data, in, Q*DATA_WIDTH*LANES, per-channel write word.
- swap_req, in, 1, pulse; exchanges the current and next banks.
- swap_ack, out, 1, one-cycle pulse when a swap is taken.
- bank_sel, out, 1, index of the current (read) bank.
- step_count, out, 32, number of completed swaps.
- busy, out, 1, high while in INIT.
- init_done, out, 1, one-cycle pulse at the end of INIT.
- addr_err, out, 1, sticky out-of-range access flag.

Function
REQ-003 Storage: 2*Q RAMs, each DEPTH x (DATA_WIDTH*LANES), arranged as bank 0 and bank 1 per channel.
REQ-004 Reads: when rd_en=1 at edge N, rd_data holds the bank[bank_sel sampled at N] contents of each channel's rd_addr, and rd_valid=1 after edge N+1; rd_valid=0 otherwise.
REQ-005 Writes: when wr_en[q]=1 at edge N, wr_data[q] is written into channel q of bank !bank_sel (value sampled at N); a read from that bank first sees the data at edge N+1.
REQ-006 FSM: IDLE -> INIT on init_start; INIT -> RUN after DEPTH fill cycles; RUN -> INIT on init_start.
REQ-007 INIT behaviour:
- Counter a steps 0..DEPTH-1, one address per cycle.
- At each a, both banks of channel q receive init_vals[q] replicated into all LANES.
- init_vals is sampled once, at init_start.
- bank_sel is forced to 0; step_count is cleared to 0.
REQ-008 INIT exit: on the cycle the fill of address DEPTH-1 commits, init_done pulses, busy falls, and the FSM enters RUN.
REQ-009 During INIT: rd_en, wr_en and swap_req are ignored and rd_valid stays 0; init_start restarts the fill from a=0.
REQ-010 In IDLE and RUN, reads and writes are honoured; memory contents are undefined until the first INIT completes.
REQ-011 Swap: swap_req=1 in RUN at edge N toggles bank_sel at N, asserts swap_ack for one cycle, and increments step_count (wraps 2^32-1 -> 0). swap_req in IDLE is ignored.
REQ-012 Write and swap in the same cycle: the write commits to the pre-swap next bank.
REQ-013 Read and swap in the same cycle: the read returns pre-swap current-bank data.
REQ-014 Out-of-range addresses: any strobed rd_addr[q] or wr_addr[q] >= DEPTH sets addr_err.
- An out-of-range write is dropped.
- An out-of-range read returns 0 for that channel.
- addr_err clears only on reset or init_start.

Reset
REQ-015 While rst=0, asynchronously and independent of clk:
- state = IDLE;
- bank_sel, step_count, rd_valid, rd_data, swap_ack, busy, init_done and addr_err = 0;
- fill counter = 0.
Memory contents are not reset.
REQ-016 Reset asserted mid-INIT or mid-RUN aborts the operation; after release the block is in IDLE and needs init_start.

Configuration
REQ-017 Macro LBM_DIST_BANK_DEBUG_EN:
- When defined, add outputs dbg_c0_wr_data (DATA_WIDTH*LANES) and dbg_c0_rd_data (DATA_WIDTH*LANES). These combinationally mirror channel 0 of the write-data mux (including INIT fill data) and of rd_data.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-018 Directed scenarios:
- Q=9, DEPTH=16: reset, init_start with init_vals[q]=q+1 -> busy high for 16 cycles, init_done pulses; every address in both banks reads {LANES{q+1}}.
- RUN: write ch4 addr 3 = 0x00AA00BB00CC00DD, then swap_req -> swap_ack pulses, bank_sel=1, step_count=1; read ch4 addr 3 -> that word with rd_valid one cycle after rd_en.
- wr_en[2] and swap_req in the same cycle -> the data lands in the old next bank and is readable immediately after the swap; step_count increments once.
- rd_addr[0]=16 with DEPTH=16 -> rd_data ch0=0, addr_err=1 and stays 1 until init_start.
- rst pulled low at fill address 7 -> all outputs 0 immediately; after release, swap_req is ignored (IDLE) and step_count stays 0.
- Preload step_count 0xFFFFFFFF via forced swaps, swap again -> step_count=0 and bank_sel toggles.
